ps2_rx_frame_ctrl: RTL and testbench

Receive-side controller for the PS/2 keyboard port. It synchronizes and filters the PS/2 clock and data lines, sequences reception of 11-bit frames, validates each frame, and merges 0xE0/0xF0 prefixes into one key event. It drives the keyboard watchdog timer (kick output, done input) so that a stalled or partial frame is aborted and the receiver resynchronizes. It sits between the PS/2 pins and the game input decoder.

---
 rtl/ps2_rx_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ps2_rx_frame_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame_ctrl.sv
// PS/2 receive frame controller: sync/filter, 11-bit frame FSM,
// E0/F0 prefix merge, keyboard watchdog kick/abort.
//
// Ports:
//   sys_clk, reset_n        clock, async active-low reset
//   ps2_clk, ps2_data       raw PS/2 pins (asynchronous)
//   wdt_done / wdt_kick     watchdog expiry in / clear request out
//   key_code/ext/break      last decoded key event (held)
//   key_valid               1-cycle pulse, key event updated
//   frame_err               1-cycle pulse, bad parity/stop
//   timeout                 1-cycle pulse, frame aborted
module ps2_rx_frame_ctrl #(
  parameter int FILTER_LEN = 4
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       wdt_done,
  output logic       wdt_kick,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err,
  output logic       timeout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [3:0] FLT_MAX = 4'(FILTER_LEN - 1);

  logic [1:0] clk_s;
  logic [1:0] data_s;
  logic [3:0] flt_cnt;
  logic       filt_clk;
  logic       filt_q;
  logic       sample;
  logic       bit_d;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par_bit;
  logic       ext;
  logic       brk;
  logic       good;

  // Clock synchronizer resets to the idle-high level so that
  // leaving reset never looks like a falling PS/2 clock.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s  <= 2'b11;
      data_s <= 2'b00;
    end else begin
      clk_s  <= {clk_s[0], ps2_clk};
      data_s <= {data_s[0], ps2_data};
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt  <= 4'd0;
      filt_clk <= 1'b1;
      filt_q   <= 1'b1;
    end else begin
      filt_q <= filt_clk;
      if (clk_s[1] != filt_clk) begin
        if (flt_cnt == FLT_MAX) begin
          filt_clk <= clk_s[1];
          flt_cnt  <= 4'd0;
        end else begin
          flt_cnt <= flt_cnt + 4'd1;
        end
      end else begin
        flt_cnt <= 4'd0;
      end
    end
  end

  assign sample = filt_q & ~filt_clk;
  assign bit_d  = data_s[1];

  // Stop bit high and odd parity over data + parity bit.
  assign good = bit_d & (^{shift, par_bit});

  assign wdt_kick = (state == IDLE) | sample;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      par_bit   <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      key_code  <= 8'd0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      if (wdt_done && state != IDLE) begin
        state   <= IDLE;
        timeout <= 1'b1;
        shift   <= 8'd0;
        bit_cnt <= 3'd0;
        ext     <= 1'b0;
        brk     <= 1'b0;
      end else if (sample) begin
        unique case (state)
          IDLE: begin
            if (!bit_d) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift   <= {bit_d, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par_bit <= bit_d;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (good) begin
              if (shift == 8'hE0) begin
                ext <= 1'b1;
              end else if (shift == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                key_code  <= shift;
                key_ext   <= ext;
                key_break <= brk;
                key_valid <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame_ctrl.sv
// Self-checking bench for ps2_rx_frame_ctrl.
// Scoreboard of expected pulses, popped by an output monitor.
module tb_ps2_rx_frame_ctrl;

  localparam int FL = 4;

  logic       sys_clk = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       wdt_done;
  logic       wdt_kick;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       frame_err;
  logic       timeout;

  ps2_rx_frame_ctrl #(.FILTER_LEN(FL)) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .wdt_done (wdt_done),
    .wdt_kick (wdt_kick),
    .key_code (key_code),
    .key_ext  (key_ext),
    .key_break(key_break),
    .key_valid(key_valid),
    .frame_err(frame_err),
    .timeout  (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } exp_t;

  localparam logic [2:0] K_KEY = 3'b001;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_TO  = 3'b100;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [2:0] k, input logic [7:0] c,
                      input logic e, input logic b);
    exp_t x;
    x.kind = k;
    x.code = c;
    x.ext  = e;
    x.brk  = b;
    sb.push_back(x);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    cyc(10);
    if (glitch) begin
      ps2_clk = 1'b0;
      cyc(FL - 1);
      ps2_clk = 1'b1;
      cyc(10);
    end
    ps2_clk = 1'b0;
    cyc(20);
    ps2_clk = 1'b1;
    cyc(10);
  endtask

  // nbits < 11 sends a truncated frame (start bit first).
  task automatic send_frame(input logic [7:0] b, input bit par_err,
                            input logic stop, input int gbit,
                            input int nbits);
    logic [10:0] f;
    logic        p;
    p = (~^b) ^ par_err;
    f = {stop, p, b, 1'b0};
    for (int i = 0; i < nbits; i++)
      send_bit(f[i], i == gbit);
    ps2_data = 1'b1;
    cyc(20);
  endtask

  always @(negedge sys_clk) begin
    if (key_valid | frame_err | timeout) begin
      if (sb.size() == 0) begin
        chk("unexp_pulse", {29'd0, timeout, frame_err, key_valid}, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("kind", {29'd0, timeout, frame_err, key_valid},
            {29'd0, x.kind});
        if (x.kind == K_KEY) begin
          chk("key_code", {24'd0, key_code}, {24'd0, x.code});
          chk("key_ext", {31'd0, key_ext}, {31'd0, x.ext});
          chk("key_break", {31'd0, key_break}, {31'd0, x.brk});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_code"}, {24'd0, key_code}, 0);
    chk({tag, "_ext"}, {31'd0, key_ext}, 0);
    chk({tag, "_brk"}, {31'd0, key_break}, 0);
    chk({tag, "_valid"}, {31'd0, key_valid}, 0);
    chk({tag, "_err"}, {31'd0, frame_err}, 0);
    chk({tag, "_to"}, {31'd0, timeout}, 0);
    chk({tag, "_kick"}, {31'd0, wdt_kick}, 1);
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wdt_done = 1'b0;
    cyc(3);
    @(negedge sys_clk);
    chk_rst("rst");
    reset_n = 1'b1;
    cyc(10);

    push(K_KEY, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, -1, 11);

    push(K_KEY, 8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1, -1, 11);
    send_frame(8'hF0, 1'b0, 1'b1, -1, 11);
    send_frame(8'h75, 1'b0, 1'b1, -1, 11);
    push(K_KEY, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, -1, 11);

    push(K_ERR, 8'h00, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, -1, 11);
    push(K_ERR, 8'h00, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, -1, 11);
    push(K_KEY, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, -1, 11);

    send_frame(8'h29, 1'b0, 1'b1, -1, 5);
    cyc(50);
    @(negedge sys_clk);
    chk("kick_busy", {31'd0, wdt_kick}, 0);
    cyc(50);
    push(K_TO, 8'h00, 1'b0, 1'b0);
    wdt_done = 1'b1;
    cyc(1);
    wdt_done = 1'b0;
    @(negedge sys_clk);
    chk("kick_after_to", {31'd0, wdt_kick}, 1);
    cyc(10);
    push(K_KEY, 8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, -1, 11);

    ps2_clk = 1'b0;
    cyc(FL - 1);
    ps2_clk = 1'b1;
    cyc(20);
    push(K_KEY, 8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 4, 11);

    send_frame(8'h33, 1'b0, 1'b1, -1, 4);
    reset_n = 1'b0;
    #3;
    chk_rst("midrst");
    cyc(5);
    reset_n = 1'b1;
    cyc(10);
    push(K_KEY, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, -1, 11);

    cyc(20);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
